// File: rtl/cmp_seq_ctrl_if.sv
// Handshake/result bundle between the push-button compare sequencer and its
// surroundings: raw button and operands in, registered result flags out.
interface cmp_seq_ctrl_if #(
    parameter int WIDTH = 9
);
    logic             PB;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             oeq;
    logic             ogt;
    logic             olt;
    logic [3:0]       idx;
    logic             busy;
    logic             done;

    modport master (
        output PB, a, b,
        input  oeq, ogt, olt, idx, busy, done
    );

    modport slave (
        input  PB, a, b,
        output oeq, ogt, olt, idx, busy, done
    );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Debounced push-button sequencer running an MSB-first bit-serial unsigned
// magnitude compare; the result is held until the next accepted press.
module cmp_seq_ctrl #(
    parameter int WIDTH      = 9,
    parameter int DEB_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    cmp_seq_ctrl_if.slave  bus
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [3:0]    PTR_TOP  = 4'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [3:0]       ptr_reg, ptr_next;
    logic             oeq_reg, oeq_next;
    logic             ogt_reg, ogt_next;
    logic             olt_reg, olt_next;
    logic [3:0]       idx_reg, idx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic msb_differ;
    assign msb_differ = sa_reg[WIDTH-1] ^ sb_reg[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (bus.PB) state_next = DEBOUNCE;
            DEBOUNCE: begin
                if (!bus.PB)                 state_next = IDLE;
                else if (cnt_reg == CNT_LAST) state_next = SHIFT;
            end
            SHIFT:    if (msb_differ || ptr_reg == 4'd0) state_next = DONE;
            DONE:     if (!bus.PB) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath and result updates; results only move at capture and completion.
    always_comb begin
        cnt_next  = cnt_reg;
        sa_next   = sa_reg;
        sb_next   = sb_reg;
        ptr_next  = ptr_reg;
        oeq_next  = oeq_reg;
        ogt_next  = ogt_reg;
        olt_next  = olt_reg;
        idx_next  = idx_reg;
        done_next = 1'b0;
        busy_next = (state_next == DEBOUNCE) || (state_next == SHIFT);
        case (state_reg)
            IDLE: if (bus.PB) cnt_next = CW'(1);
            DEBOUNCE: begin
                if (bus.PB) begin
                    if (cnt_reg == CNT_LAST) begin
                        sa_next  = bus.a;
                        sb_next  = bus.b;
                        ptr_next = PTR_TOP;
                        oeq_next = 1'b0;
                        ogt_next = 1'b0;
                        olt_next = 1'b0;
                        idx_next = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (msb_differ) begin
                    ogt_next  = sa_reg[WIDTH-1];
                    olt_next  = sb_reg[WIDTH-1];
                    idx_next  = ptr_reg;
                    done_next = 1'b1;
                end else if (ptr_reg == 4'd0) begin
                    oeq_next  = 1'b1;
                    idx_next  = 4'hF;
                    done_next = 1'b1;
                end else begin
                    sa_next  = {sa_reg[WIDTH-2:0], 1'b0};
                    sb_next  = {sb_reg[WIDTH-2:0], 1'b0};
                    ptr_next = ptr_reg - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            sa_reg   <= '0;
            sb_reg   <= '0;
            ptr_reg  <= 4'd0;
            oeq_reg  <= 1'b0;
            ogt_reg  <= 1'b0;
            olt_reg  <= 1'b0;
            idx_reg  <= 4'd0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            sa_reg   <= sa_next;
            sb_reg   <= sb_next;
            ptr_reg  <= ptr_next;
            oeq_reg  <= oeq_next;
            ogt_reg  <= ogt_next;
            olt_reg  <= olt_next;
            idx_reg  <= idx_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign bus.oeq  = oeq_reg;
    assign bus.ogt  = ogt_reg;
    assign bus.olt  = olt_reg;
    assign bus.idx  = idx_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl: expected results are queued at press time
// and checked (value and latency) when done pulses.
module tb_cmp_seq_ctrl;
    localparam int W   = 9;
    localparam int DEB = 4;

    typedef struct {
        logic       eq;
        logic       gt;
        logic       lt;
        logic [3:0] idx;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [6:0] last_vec = 7'd0;

    cmp_seq_ctrl_if #(.WIDTH(W)) bus();

    cmp_seq_ctrl #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.eq  = (av == bv);
        e.gt  = (av > bv);
        e.lt  = (av < bv);
        e.idx = 4'hF;
        e.lat = W;
        for (int i = 0; i < W; i++) begin
            if (av[i] != bv[i]) begin
                e.idx = 4'(i);
                e.lat = W - i;
            end
        end
        return e;
    endfunction

    function automatic logic [6:0] res_vec();
        return {bus.oeq, bus.ogt, bus.olt, bus.idx};
    endfunction

    // Press PB (starting from IDLE with PB low) and track the compare to done.
    task automatic run_compare(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input bit scramble, input bit hold_pb);
        exp_t e;
        int   n;
        bit   seen;
        sb_q.push_back(model(av, bv));
        @(negedge clk);
        bus.a  = av;
        bus.b  = bv;
        bus.PB = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (n == DEB) begin
                tests++;
                if ({bus.busy, bus.oeq, bus.ogt, bus.olt, bus.idx} !== 8'h80) begin
                    errors++;
                    $display("FAIL capture_clear: got busy/eq/gt/lt/idx=%b required 10000000",
                             {bus.busy, bus.oeq, bus.ogt, bus.olt, bus.idx});
                end
            end
            if (scramble && n == DEB + 1) begin
                bus.a = ~av;
                bus.b = W'($urandom);
            end
            if (bus.done === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: a=%h b=%h no done within %0d edges", av, bv, n);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            last_vec = {e.eq, e.gt, e.lt, e.idx};
            $display("cmp a=%h b=%h -> eq=%b gt=%b lt=%b idx=%h at E0+%0d",
                     av, bv, bus.oeq, bus.ogt, bus.olt, bus.idx, n - DEB);
            if (res_vec() !== last_vec) begin
                errors++;
                $display("FAIL result: got eq/gt/lt/idx=%b required %b", res_vec(), last_vec);
            end
            tests++;
            if (n !== DEB + e.lat) begin
                errors++;
                $display("FAIL latency: got E0+%0d required E0+%0d", n - DEB, e.lat);
            end
            tests++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done: got %b required 0", bus.busy);
            end
            @(negedge clk);
            tests++;
            if (bus.done !== 1'b0 || res_vec() !== last_vec) begin
                errors++;
                $display("FAIL done_pulse_hold: got done=%b res=%b required 0 %b",
                         bus.done, res_vec(), last_vec);
            end
        end
        if (!hold_pb) begin
            bus.PB = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.PB = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({res_vec(), bus.busy, bus.done} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: got %b required 0", {res_vec(), bus.busy, bus.done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_press();
        run_compare(9'b111111011, 9'b111101111, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || res_vec() !== last_vec) begin
            errors++;
            $display("FAIL held_no_retrigger: got busy=%b res=%b required 0 %b",
                     bus.busy, res_vec(), last_vec);
        end
        bus.PB = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mismatch();
        run_compare(9'b111111110, 9'b101111111, 1'b0, 1'b0);
        run_compare(9'b111011111, 9'b111111101, 1'b0, 1'b0);
        run_compare(9'b110111111, 9'b111011111, 1'b0, 1'b0);
    endtask

    task automatic test_equal_hold();
        int dones;
        run_compare(9'h1A5, 9'h1A5, 1'b0, 1'b1);
        bus.a = 9'h000;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        tests++;
        if (dones !== 0 || res_vec() !== last_vec) begin
            errors++;
            $display("FAIL equal_hold: got dones=%0d res=%b required 0 %b", dones, res_vec(), last_vec);
        end
        bus.PB = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_glitch();
        int dones;
        dones = 0;
        for (int r = 0; r < 3; r++) begin
            bus.PB = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (bus.done === 1'b1) dones++;
            end
            bus.PB = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (bus.done === 1'b1) dones++;
            end
        end
        $display("glitch x3 -> dones=%0d busy=%b res=%b", dones, bus.busy, res_vec());
        tests++;
        if (dones !== 0 || bus.busy !== 1'b0 || res_vec() !== last_vec) begin
            errors++;
            $display("FAIL glitch: got dones=%0d busy=%b res=%b required 0 0 %b",
                     dones, bus.busy, res_vec(), last_vec);
        end
    endtask

    task automatic test_operand_change();
        run_compare(9'h0F0, 9'h0E1, 1'b1, 1'b0);
        run_compare(9'h003, 9'h002, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        int dones;
        @(negedge clk);
        bus.a  = 9'h001;
        bus.b  = 9'h000;
        bus.PB = 1'b1;
        repeat (DEB + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("abort mid-shift -> busy=%b done=%b res=%b", bus.busy, bus.done, res_vec());
        tests++;
        if ({res_vec(), bus.busy, bus.done} !== 9'd0) begin
            errors++;
            $display("FAIL abort_async: got %b required 0", {res_vec(), bus.busy, bus.done});
        end
        bus.PB = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        tests++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_idle: got %0d busy/done cycles required 0", dones);
        end
        run_compare(9'h001, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av, bv;
        for (int i = 0; i < 6; i++) begin
            av = W'($urandom);
            bv = (i == 2) ? av : W'($urandom);
            run_compare(av, bv, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_held_press();
        test_mismatch();
        test_equal_hold();
        test_glitch();
        test_operand_change();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
        $finish;
    end
endmodule
